// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operand sequencer: state and opcode encodings, flag bundle.
package alu_seq_pkg;

  localparam int unsigned ALU_WIDTH = 10;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADC  = 2'd2,
    OP_PASS = 2'd3
  } op_t;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/btn_conditioner.sv
// Button path: 2-flop synchroniser, optional debouncer (ALU_SEQ_DEBOUNCE_EN), registered rising-edge pulse.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic adv
);

  logic [1:0] sync_q;
  logic       lvl;
  logic       lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], btn_raw};
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0] cnt_q;
  logic          db_q;

  // Count consecutive cycles the synchronised level disagrees with the debounced one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else if (sync_q[1] == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q <= '0;
      db_q  <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign lvl = db_q;
`else
  assign lvl = sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= 1'b0;
      adv   <= 1'b0;
    end else begin
      lvl_q <= lvl;
      adv   <= lvl & ~lvl_q;
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Captures A, B and opcode from switches on successive button presses, drives the external adder,
// registers sum/carry and Z/N/V flags. Optional debouncer enabled by ALU_SEQ_DEBOUNCE_EN.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH           = ALU_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_next,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             result_valid,
  output logic [2:0]       state
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  op_t              op_q, op_sw;
  flags_t           flags_q;
  logic             adv;
  logic [WIDTH-1:0] drv_b;
  logic             drv_cin;
  logic             ovf;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_next),
    .adv    (adv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD_A;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A:  if (adv) state_d = LOAD_B;
      LOAD_B:  if (adv) state_d = LOAD_OP;
      LOAD_OP: if (adv) state_d = EXEC;
      EXEC:    state_d = SHOW;
      SHOW:    if (adv) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  // Effective adder operands decoded straight from the switches at the opcode capture edge.
  always_comb begin
    op_sw   = op_t'(sw[1:0]);
    drv_b   = b_q;
    drv_cin = 1'b0;
    case (op_sw)
      OP_SUB: begin
        drv_b   = ~b_q;
        drv_cin = 1'b1;
      end
      OP_ADC:  drv_cin = sw[2];
      OP_PASS: drv_b   = '0;
      default: ;
    endcase
  end

  assign ovf = (add_a[WIDTH-1] == add_b[WIDTH-1]) & (add_s[WIDTH-1] != add_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      add_a        <= '0;
      add_b        <= '0;
      add_cin      <= 1'b0;
      result       <= '0;
      flags_q      <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state_q)
        LOAD_A:  if (adv) a_q <= sw;
        LOAD_B:  if (adv) b_q <= sw;
        LOAD_OP: if (adv) begin
          op_q    <= op_sw;
          add_a   <= a_q;
          add_b   <= drv_b;
          add_cin <= drv_cin;
        end
        EXEC: begin
          result       <= add_s;
          flags_q.c    <= (op_q == OP_PASS) ? 1'b0 : add_cout;
          flags_q.z    <= (add_s == '0);
          flags_q.n    <= add_s[WIDTH-1];
          flags_q.v    <= (op_q == OP_PASS) ? 1'b0 : ovf;
          result_valid <= 1'b1;
        end
        SHOW:    if (adv) result_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign flag_c = flags_q.c;
  assign flag_z = flags_q.z;
  assign flag_n = flags_q.n;
  assign flag_v = flags_q.v;
  assign state  = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench: cycle-level behavioural model of the sequencer plus directed literal checks.
`timescale 1ns/1ps
module tb_alu_operand_sequencer;

  localparam int W  = 10;
  localparam int DC = 16;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int LAT  = DC + 3;
  localparam int HOLD = 20;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 3;
`endif
  localparam int GAP = LAT + 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         btn_next = 1'b0;
  logic [W-1:0] sw = '0;
  logic [W-1:0] add_a, add_b, add_s, result;
  logic         add_cin, add_cout;
  logic         flag_c, flag_z, flag_n, flag_v, result_valid;
  logic [2:0]   state;

  int total = 0;
  int bad   = 0;

  alu_operand_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_next(btn_next),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .result(result), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .result_valid(result_valid), .state(state)
  );

  // Stand-in for the external ripple-carry adder
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_state;
  logic [W-1:0] m_a, m_b, m_adda, m_addb, m_res;
  logic [1:0]   m_op;
  logic         m_cin, m_c, m_z, m_n, m_v, m_valid;
  logic [31:0]  h;      // h[i] = btn_next sampled i edges ago
  logic         fire;
  logic [W:0]   sum_v;
`ifdef ALU_SEQ_DEBOUNCE_EN
  logic         m_deb, rise;
  logic [2:0]   r;
`endif

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_state = 0; m_a = '0; m_b = '0; m_adda = '0; m_addb = '0; m_res = '0;
      m_op = '0; m_cin = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0; m_valid = 0;
      h = '0;
`ifdef ALU_SEQ_DEBOUNCE_EN
      m_deb = 0; r = '0;
`endif
    end else begin
      h = {h[30:0], btn_next};
`ifdef ALU_SEQ_DEBOUNCE_EN
      // level flips once the last DC synchronised samples all disagree with it
      rise = 0;
      if (!m_deb && (&h[DC+1:2])) begin m_deb = 1; rise = 1; end
      else if (m_deb && !(|h[DC+1:2])) m_deb = 0;
      r = {r[1:0], rise};
      fire = r[2];
`else
      fire = h[3] & ~h[4];
`endif
      case (m_state)
        0: if (fire) begin m_a = sw; m_state = 1; end
        1: if (fire) begin m_b = sw; m_state = 2; end
        2: if (fire) begin
          m_op = sw[1:0];
          m_adda = m_a;
          case (m_op)
            2'd0: begin m_addb = m_b;  m_cin = 0;     end
            2'd1: begin m_addb = ~m_b; m_cin = 1;     end
            2'd2: begin m_addb = m_b;  m_cin = sw[2]; end
            default: begin m_addb = '0; m_cin = 0;    end
          endcase
          m_state = 3;
        end
        3: begin
          sum_v = {1'b0, m_adda} + {1'b0, m_addb} + {{W{1'b0}}, m_cin};
          m_res = sum_v[W-1:0];
          m_c = (m_op == 2'd3) ? 1'b0 : sum_v[W];
          m_z = (m_res == '0);
          m_n = m_res[W-1];
          m_v = (m_op == 2'd3) ? 1'b0 :
                ((m_adda[W-1] == m_addb[W-1]) && (m_res[W-1] != m_adda[W-1]));
          m_valid = 1;
          m_state = 4;
        end
        default: if (fire) begin m_valid = 0; m_state = 0; end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("m_state",   state,        m_state);
      chk("m_valid",   result_valid, m_valid);
      chk("m_result",  result,       m_res);
      chk("m_flag_c",  flag_c,       m_c);
      chk("m_flag_z",  flag_z,       m_z);
      chk("m_flag_n",  flag_n,       m_n);
      chk("m_flag_v",  flag_v,       m_v);
      chk("m_add_a",   add_a,        m_adda);
      chk("m_add_b",   add_b,        m_addb);
      chk("m_add_cin", add_cin,      m_cin);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [W-1:0] v);
    @(negedge clk);
    sw = v;
    btn_next = 1'b1;
    cyc(HOLD);
    btn_next = 1'b0;
    cyc(GAP);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_state"}, state, 0);
    chk({nm, "_result"}, result, 0);
    chk({nm, "_flags"}, {flag_c, flag_z, flag_n, flag_v}, 0);
    chk({nm, "_valid"}, result_valid, 0);
    chk({nm, "_adder"}, {add_a, add_b, add_cin}, 0);
  endtask

  int n;

  initial begin
    cyc(3);
    chk_reset("por");
    rst_n = 1'b1;
    cyc(2);

    // reset mid-sequence in LOAD_B
    press(10'h155);
    chk("loadb_state", state, 1);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk_reset("mid_rst");
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // held button gives a single advance
    @(negedge clk);
    sw = 10'h0AB; btn_next = 1'b1;
    cyc(20);
    btn_next = 1'b0;
    cyc(GAP);
    chk("held_once", state, 1);
    press(10'h001); press(10'h000);
    chk("add_small", result, 10'h0AC);
    press(10'h000);

    // ADD with signed overflow
    press(10'h1FF); press(10'h001); press(10'h000);
    chk("add_res", result, 10'h200);
    chk("add_cznv", {flag_c, flag_z, flag_n, flag_v}, 4'b0011);
    chk("add_valid", result_valid, 1);
    press(10'h000);

    // SUB to zero
    press(10'h005); press(10'h005); press(10'h001);
    chk("sub_addb", add_b, 10'h3FA);
    chk("sub_cin", add_cin, 1);
    chk("sub_res", result, 10'h000);
    chk("sub_cznv", {flag_c, flag_z, flag_n, flag_v}, 4'b1100);
    press(10'h000);

    // ADC wrap with carry-in
    press(10'h3FF); press(10'h000); press(10'h006);
    chk("adc_res", result, 10'h000);
    chk("adc_czv", {flag_c, flag_z, flag_v}, 3'b110);
    press(10'h000);
    chk("show_exit_state", state, 0);
    chk("show_exit_valid", result_valid, 0);
    chk("show_exit_res", result, 10'h000);

    // PASS_A, switches wiggled during SHOW
    press(10'h2AA); press(10'h123); press(10'h003);
    chk("pass_res", result, 10'h2AA);
    chk("pass_ncv", {flag_n, flag_c, flag_v}, 3'b100);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sw = W'(i * 10'h055);
    end
    cyc(2);
    chk("pass_hold_res", result, 10'h2AA);
    chk("pass_hold_state", state, 4);
    chk("pass_hold_valid", result_valid, 1);
    press(10'h000);

    // press-to-action latency, bounded wait
    @(negedge clk);
    sw = 10'h011; btn_next = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (state != 3'd0) break;
    end
    chk("adv_latency", n, LAT + 1);
    cyc(HOLD);
    btn_next = 1'b0;
    cyc(GAP);
    chk("latency_state", state, 1);

`ifdef ALU_SEQ_DEBOUNCE_EN
    // short glitch is filtered out
    @(negedge clk);
    btn_next = 1'b1;
    cyc(5);
    btn_next = 1'b0;
    cyc(30);
    chk("glitch_state", state, 1);
`endif

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
